// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: bubble word, system
// instruction encodings that stop fetch, and the fetch FSM state type.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] ECALL_INST       = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  function automatic logic is_halt_inst(input logic [31:0] inst);
    return (inst == ECALL_INST) || (inst == EBREAK_INST);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority inside one cycle: rst > bubble > hold > load;
// a bubble squashes the instruction but keeps the PC pair for later debug visibility.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic        hold,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pc4,
  input  logic [31:0] fetch_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
    end else if (bubble) begin
      ifid_inst  <= NOP_INST;
      ifid_valid <= 1'b0;
    end else if (load && !hold) begin
      ifid_pc    <= fetch_pc;
      ifid_pc4   <= fetch_pc4;
      ifid_inst  <= fetch_inst;
      ifid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection, RUN/HALT control
// and issued-instruction counter, feeding the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic [5:0]  imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  fetch_state_e state, next_state;
  logic [31:0]  pc_next, count_next, pc_plus4;
  logic         load, bubble, hold;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[7:2];
  assign halted    = (state == HALT);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    count_next = fetch_count;
    load       = 1'b0;
    bubble     = 1'b0;
    hold       = 1'b0;
    if (flush) begin
      pc_next    = {redirect_pc[31:2], 2'b00};
      bubble     = 1'b1;
      next_state = RUN;
    end else if (stall) begin
      hold = 1'b1;
    end else if (state == RUN) begin
      load       = 1'b1;
      count_next = fetch_count + 32'd1;
      if (is_halt_inst(imem_data)) begin
        next_state = HALT;  // the system instruction itself still issues
      end else begin
        pc_next = pc_plus4;
      end
    end else begin
      bubble = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= '0;
      fetch_count <= '0;
    end else begin
      state       <= next_state;
      pc          <= pc_next;
      fetch_count <= count_next;
    end
  end

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bubble     (bubble),
    .hold       (hold),
    .fetch_pc   (pc),
    .fetch_pc4  (pc_plus4),
    .fetch_inst (imem_data),
    .ifid_pc    (ifid_pc),
    .ifid_pc4   (ifid_pc4),
    .ifid_inst  (ifid_inst),
    .ifid_valid (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk, rst, stall, flush;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc, ifid_pc, ifid_pc4, ifid_inst, fetch_count;
  logic        ifid_valid, halted;

  logic        use_mem;
  logic [31:0] drv_inst;
  logic [31:0] mem [64];

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_ifid_pc, m_ifid_pc4, m_inst, m_count;
  logic        m_valid, m_halted;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .pc          (pc),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4),
    .ifid_inst   (ifid_inst),
    .ifid_valid  (ifid_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_data = use_mem ? mem[imem_addr] : drv_inst;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] target);
    flush = 1'b1; redirect_pc = target;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    use_mem = 1'b0; drv_inst = 32'h1234_5678;
    do_reset();
    n_total++; if (pc !== 32'h0)        $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
    n_total++; if (ifid_pc !== 32'h0)   $display("FAIL reset_ifid_pc: got %h want 0", ifid_pc); else n_pass++;
    n_total++; if (ifid_pc4 !== 32'h0)  $display("FAIL reset_ifid_pc4: got %h want 0", ifid_pc4); else n_pass++;
    n_total++; if (ifid_inst !== NOP)   $display("FAIL reset_inst: got %h want %h", ifid_inst, NOP); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifid_valid); else n_pass++;
    n_total++; if (halted !== 1'b0)     $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (fetch_count !== 0)   $display("FAIL reset_count: got %0d want 0", fetch_count); else n_pass++;
    n_total++; if (imem_addr !== 6'd0)  $display("FAIL reset_imem_addr: got %0d want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_free_run();
    logic [31:0] words [3];
    words[0] = 32'h0000_2083; words[1] = 32'h0040_2103; words[2] = 32'h0020_81b3;
    use_mem = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv_inst = words[i];
      tick();
      n_total++; if (ifid_pc !== 32'(i * 4)) $display("FAIL run_ifid_pc[%0d]: got %h want %h", i, ifid_pc, 32'(i * 4)); else n_pass++;
      n_total++; if (ifid_inst !== words[i]) $display("FAIL run_inst[%0d]: got %h want %h", i, ifid_inst, words[i]); else n_pass++;
      n_total++; if (ifid_valid !== 1'b1)    $display("FAIL run_valid[%0d]: got %b want 1", i, ifid_valid); else n_pass++;
    end
    n_total++; if (fetch_count !== 32'd3) $display("FAIL run_count: got %0d want 3", fetch_count); else n_pass++;
    n_total++; if (imem_addr !== 6'd3)    $display("FAIL run_imem_addr: got %0d want 3", imem_addr); else n_pass++;
    n_total++; if (ifid_pc4 !== 32'hC)    $display("FAIL run_ifid_pc4: got %h want c", ifid_pc4); else n_pass++;
  endtask

  task automatic test_stall();
    use_mem = 1'b0;
    do_reset();
    drv_inst = 32'h0000_2083; tick();
    drv_inst = 32'h0040_2103; tick();
    stall = 1'b1; drv_inst = 32'h0020_81b3;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (pc !== 32'h8)             $display("FAIL stall_pc[%0d]: got %h want 8", i, pc); else n_pass++;
      n_total++; if (ifid_pc !== 32'h4)        $display("FAIL stall_ifid_pc[%0d]: got %h want 4", i, ifid_pc); else n_pass++;
      n_total++; if (ifid_inst !== 32'h0040_2103) $display("FAIL stall_inst[%0d]: got %h want 00402103", i, ifid_inst); else n_pass++;
      n_total++; if (fetch_count !== 32'd2)    $display("FAIL stall_count[%0d]: got %0d want 2", i, fetch_count); else n_pass++;
    end
    stall = 1'b0; tick();
    n_total++; if (ifid_pc !== 32'h8)     $display("FAIL resume_ifid_pc: got %h want 8", ifid_pc); else n_pass++;
    n_total++; if (fetch_count !== 32'd3) $display("FAIL resume_count: got %0d want 3", fetch_count); else n_pass++;
  endtask

  task automatic test_flush_stall();
    stall = 1'b1; drv_inst = ECALL;
    redirect(32'h0000_001E);
    stall = 1'b0;
    n_total++; if (pc !== 32'h1C)          $display("FAIL flush_pc: got %h want 1c", pc); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0)    $display("FAIL flush_valid: got %b want 0", ifid_valid); else n_pass++;
    n_total++; if (ifid_inst !== NOP)      $display("FAIL flush_inst: got %h want %h", ifid_inst, NOP); else n_pass++;
    n_total++; if (imem_addr !== 6'd7)     $display("FAIL flush_imem_addr: got %0d want 7", imem_addr); else n_pass++;
    n_total++; if (ifid_pc !== 32'h8)      $display("FAIL flush_ifid_pc_hold: got %h want 8", ifid_pc); else n_pass++;
    n_total++; if (fetch_count !== 32'd3)  $display("FAIL flush_count: got %0d want 3", fetch_count); else n_pass++;
  endtask

  task automatic test_halt();
    logic [31:0] cnt;
    use_mem = 1'b0; drv_inst = 32'h0000_2083;
    redirect(32'h10);
    // stall coinciding with ECALL: nothing latched, still running
    stall = 1'b1; drv_inst = ECALL; tick(); stall = 1'b0;
    n_total++; if (halted !== 1'b0) $display("FAIL stall_ecall_halted: got %b want 0", halted); else n_pass++;
    cnt = fetch_count;
    tick();
    n_total++; if (ifid_inst !== ECALL)   $display("FAIL halt_inst: got %h want %h", ifid_inst, ECALL); else n_pass++;
    n_total++; if (ifid_valid !== 1'b1)   $display("FAIL halt_valid: got %b want 1", ifid_valid); else n_pass++;
    n_total++; if (halted !== 1'b1)       $display("FAIL halt_halted: got %b want 1", halted); else n_pass++;
    n_total++; if (pc !== 32'h10)         $display("FAIL halt_pc: got %h want 10", pc); else n_pass++;
    n_total++; if (fetch_count !== cnt + 1) $display("FAIL halt_count: got %0d want %0d", fetch_count, cnt + 1); else n_pass++;
    drv_inst = 32'h0000_2083;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (ifid_valid !== 1'b0)     $display("FAIL halted_valid[%0d]: got %b want 0", i, ifid_valid); else n_pass++;
      n_total++; if (ifid_inst !== NOP)       $display("FAIL halted_inst[%0d]: got %h want %h", i, ifid_inst, NOP); else n_pass++;
      n_total++; if (pc !== 32'h10)           $display("FAIL halted_pc[%0d]: got %h want 10", i, pc); else n_pass++;
      n_total++; if (fetch_count !== cnt + 1) $display("FAIL halted_count[%0d]: got %0d want %0d", i, fetch_count, cnt + 1); else n_pass++;
    end
    redirect(32'h20);
    n_total++; if (halted !== 1'b0) $display("FAIL unhalt_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (pc !== 32'h20)   $display("FAIL unhalt_pc: got %h want 20", pc); else n_pass++;
    drv_inst = EBREAK; tick();
    n_total++; if (halted !== 1'b1) $display("FAIL ebreak_halted: got %b want 1", halted); else n_pass++;
    n_total++; if (pc !== 32'h20)   $display("FAIL ebreak_pc: got %h want 20", pc); else n_pass++;
    redirect(32'h0);
  endtask

  task automatic test_wrap();
    use_mem = 1'b0; drv_inst = 32'h0000_2083;
    redirect(32'hFC);
    tick();
    n_total++; if (pc !== 32'h100)    $display("FAIL wrap_pc_100: got %h want 100", pc); else n_pass++;
    n_total++; if (imem_addr !== 6'd0) $display("FAIL wrap_imem_addr: got %0d want 0", imem_addr); else n_pass++;
    redirect(32'hFFFF_FFFC);
    tick();
    n_total++; if (pc !== 32'h0)       $display("FAIL wrap_pc_0: got %h want 0", pc); else n_pass++;
    n_total++; if (ifid_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_ifid_pc: got %h want fffffffc", ifid_pc); else n_pass++;
    n_total++; if (ifid_pc4 !== 32'h0) $display("FAIL wrap_ifid_pc4: got %h want 0", ifid_pc4); else n_pass++;
  endtask

  task automatic test_reset_in_halt();
    use_mem = 1'b0; drv_inst = 32'h0000_2083;
    redirect(32'h30);
    tick();
    drv_inst = ECALL; tick();
    n_total++; if (halted !== 1'b1) $display("FAIL pre_reset_halted: got %b want 1", halted); else n_pass++;
    rst = 1'b1; flush = 1'b1; stall = 1'b1; redirect_pc = 32'h40;
    tick();
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
    n_total++; if (pc !== 32'h0)        $display("FAIL rst_halt_pc: got %h want 0", pc); else n_pass++;
    n_total++; if (ifid_pc !== 32'h0)   $display("FAIL rst_halt_ifid_pc: got %h want 0", ifid_pc); else n_pass++;
    n_total++; if (ifid_pc4 !== 32'h0)  $display("FAIL rst_halt_ifid_pc4: got %h want 0", ifid_pc4); else n_pass++;
    n_total++; if (ifid_inst !== NOP)   $display("FAIL rst_halt_inst: got %h want %h", ifid_inst, NOP); else n_pass++;
    n_total++; if (ifid_valid !== 1'b0) $display("FAIL rst_halt_valid: got %b want 0", ifid_valid); else n_pass++;
    n_total++; if (halted !== 1'b0)     $display("FAIL rst_halt_halted: got %b want 0", halted); else n_pass++;
    n_total++; if (fetch_count !== 0)   $display("FAIL rst_halt_count: got %0d want 0", fetch_count); else n_pass++;
  endtask

  // One clock of the fetch rules, applied to the model with the inputs about to be sampled.
  task automatic model_step(input logic r, input logic s, input logic f, input logic [31:0] target);
    logic [31:0] word;
    word = mem[m_pc[7:2]];
    if (r) begin
      m_pc = 0; m_ifid_pc = 0; m_ifid_pc4 = 0; m_inst = NOP; m_valid = 0; m_halted = 0; m_count = 0;
    end else if (f) begin
      m_pc = {target[31:2], 2'b00}; m_inst = NOP; m_valid = 0; m_halted = 0;
    end else if (s) begin
      // everything holds
    end else if (m_halted) begin
      m_inst = NOP; m_valid = 0;
    end else begin
      m_ifid_pc = m_pc; m_ifid_pc4 = m_pc + 4; m_inst = word; m_valid = 1; m_count = m_count + 1;
      if (word == ECALL || word == EBREAK) m_halted = 1;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic test_random();
    logic r, s, f;
    logic [31:0] t;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 24))
        0:       mem[i] = ECALL;
        1:       mem[i] = EBREAK;
        default: mem[i] = $urandom();
      endcase
    end
    use_mem = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 20);
      f = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      rst = r; stall = s; flush = f; redirect_pc = t;
      model_step(r, s, f, t);
      tick();
      n_total++; if (pc !== m_pc)                 $display("FAIL rand_pc@%0d: got %h want %h", cyc, pc, m_pc); else n_pass++;
      n_total++; if (imem_addr !== m_pc[7:2])     $display("FAIL rand_imem_addr@%0d: got %0d want %0d", cyc, imem_addr, m_pc[7:2]); else n_pass++;
      n_total++; if (ifid_pc !== m_ifid_pc)       $display("FAIL rand_ifid_pc@%0d: got %h want %h", cyc, ifid_pc, m_ifid_pc); else n_pass++;
      n_total++; if (ifid_pc4 !== m_ifid_pc4)     $display("FAIL rand_ifid_pc4@%0d: got %h want %h", cyc, ifid_pc4, m_ifid_pc4); else n_pass++;
      n_total++; if (ifid_inst !== m_inst)        $display("FAIL rand_inst@%0d: got %h want %h", cyc, ifid_inst, m_inst); else n_pass++;
      n_total++; if (ifid_valid !== m_valid)      $display("FAIL rand_valid@%0d: got %b want %b", cyc, ifid_valid, m_valid); else n_pass++;
      n_total++; if (halted !== m_halted)         $display("FAIL rand_halted@%0d: got %b want %b", cyc, halted, m_halted); else n_pass++;
      n_total++; if (fetch_count !== m_count)     $display("FAIL rand_count@%0d: got %0d want %0d", cyc, fetch_count, m_count); else n_pass++;
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = '0;
    use_mem = 1'b0; drv_inst = NOP;
    for (int i = 0; i < 64; i++) mem[i] = NOP;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_stall();
    test_flush_stall();
    test_halt();
    test_wrap();
    test_reset_in_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
- clk: input, 1, the only clock; all state updates on the rising edge.
- rst: input, 1, synchronous, active-high reset.
- stall: input, 1, hazard-unit hold request.
- flush: input, 1, taken branch/jump redirect from a later stage.
- redirect_pc: input, 32, redirect target byte address.
- imem_addr: output, 6, instruction memory word address.
- imem_data: input, 32, instruction word returned combinationally by instruction memory.
- pc: output, 32, current fetch PC.
- ifid_pc: output, 32, IF/ID latched PC.
- ifid_pc4: output, 32, IF/ID latched PC+4.
- ifid_inst: output, 32, IF/ID latched instruction.
- ifid_valid: output, 1, IF/ID holds a real instruction.
- halted: output, 1, fetch is halted on ECALL/EBREAK.
- fetch_count: output, 32, number of instructions issued into IF/ID.

REQ-002 The block SHALL have the following parameter (name, default, meaning):
- NOP_INST, 32'h00000013, bubble word (addi x0,x0,0).

Function
REQ-003 imem_addr SHALL equal pc[7:2] combinationally, with zero latency.
REQ-004 Per-cycle priority SHALL be: rst > flush > stall > normal fetch.
REQ-005 Normal fetch in state RUN (no flush, no stall) SHALL do the following:
- pc <= pc+4
- ifid_pc <= pc
- ifid_pc4 <= pc+4
- ifid_inst <= imem_data
- ifid_valid <= 1
- fetch_count increments by 1
REQ-006 On flush, regardless of stall or state, the block SHALL do the following:
- pc <= {redirect_pc[31:2],2'b00}, low two bits forced to zero.
- ifid_inst <= NOP_INST, ifid_valid <= 0.
- ifid_pc and ifid_pc4 hold their values.
- State goes to RUN.
- fetch_count does not increment.
REQ-007 On stall without flush, pc, all ifid_* registers, state and fetch_count SHALL hold their values.
REQ-008 pc+4 SHALL wrap modulo 2^32; imem_addr therefore wraps from word 63 to word 0 without special handling.
REQ-009 The FSM SHALL have two states, RUN and HALT.
REQ-010 In RUN, a normal fetch of imem_data equal to 32'h00000073 (ECALL) or 32'h00100073 (EBREAK) SHALL:
- Latch that instruction into IF/ID per REQ-005, including valid and count.
- Hold pc, not increment it.
- Move to HALT.
REQ-011 In HALT without flush or stall, each cycle SHALL set ifid_inst <= NOP_INST and ifid_valid <= 0, hold pc, and leave fetch_count unchanged.
REQ-012 In HALT, flush SHALL return the FSM to RUN per REQ-006; this covers an older branch overriding the halt.
REQ-013 halted SHALL be 1 exactly while the state is HALT.
REQ-014 fetch_count SHALL wrap modulo 2^32.
REQ-015 A stall and halt-instruction detection in the same cycle SHALL follow REQ-007: nothing is latched and the state stays RUN.

Reset
REQ-016 When rst is sampled high, the following SHALL hold on the next edge, whatever else is asserted:
- pc = 0, ifid_pc = 0, ifid_pc4 = 0
- ifid_inst = NOP_INST, ifid_valid = 0
- state = RUN, halted = 0
- fetch_count = 0
REQ-017 Reset asserted mid-operation, including in HALT or during a stall, SHALL override flush and stall in that cycle.
REQ-018 The first fetch after reset deassertion SHALL read word 0.

Structure
REQ-019 A shared package SHALL hold the following:
- NOP_INST default.
- ECALL and EBREAK encodings.
- Fetch-state enum {RUN, HALT}.
REQ-020 The IF/ID register SHALL be one sub-module, if_id_reg, with load, bubble and hold controls.
REQ-021 PC, next-PC mux, FSM and counter SHALL reside in fetch_stage.
REQ-022 There SHALL be no memory inside this block; instruction storage stays external.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Reset, then 3 free-running cycles with imem returning 0x00002083, 0x00402103, 0x002081b3 -> ifid_pc sequence 0, 4, 8; ifid_inst matches in order; fetch_count = 3; imem_addr = 3.
- Stall held 2 cycles at pc = 8 -> pc, ifid_* and fetch_count are unchanged for both cycles; resume -> ifid_pc = 8.
- flush=1 with redirect_pc = 0x0000001E while stall=1 -> next pc = 0x1C, ifid_valid = 0, ifid_inst = 0x00000013, imem_addr = 7.
- imem returns 0x00000073 at pc = 0x10 -> ifid_inst = 0x00000073, valid = 1, halted = 1, pc stays 0x10; the following cycles show valid = 0; flush to 0x20 -> halted = 0, pc = 0x20.
- pc = 0xFC, normal fetch -> pc = 0x100, imem_addr = 0; pc = 0xFFFFFFFC -> next pc = 0.
- rst asserted during HALT with flush=1 -> all outputs return to reset values next edge.
